// File: rtl/bp_eth_pkg.sv
// Shared definitions for the BedRock Ethernet TX controller: register offsets,
// TX_STATUS bit positions, the transmit FSM state type and the write byte-mask
// helper used by the register decoder.
package bp_eth_pkg;

  localparam logic [11:0] tx_buf_base      = 12'h000;
  localparam logic [11:0] tx_len_offset    = 12'h800;
  localparam logic [11:0] tx_send_offset   = 12'h808;
  localparam logic [11:0] tx_status_offset = 12'h810;
  localparam logic [11:0] tx_irq_en_offset = 12'h818;

  localparam int status_busy_bit     = 0;
  localparam int status_err_bit      = 1;
  localparam int status_irq_pend_bit = 2;

  typedef enum logic [1:0] {
    e_idle  = 2'd0,
    e_fetch = 2'd1,
    e_send  = 2'd2
  } bp_eth_tx_state_e;

  // Byte lanes touched by an access of 2**size bytes starting at lane offset;
  // lanes past the end of the 64-bit word are dropped.
  function automatic logic [7:0] bp_eth_byte_mask(input logic [2:0] size,
                                                  input logic [2:0] offset);
    logic [7:0]  nbytes;
    logic [15:0] span;
    nbytes = 8'd1 << size;
    span   = (16'd1 << nbytes) - 16'd1;
    return 8'(span << offset);
  endfunction

endpackage

// File: rtl/ethernet_tx_buffer.sv
// Packet buffer: 64-bit x els_p one-read/one-write memory with per-byte write
// mask and a one-cycle synchronous registered read. Behavioural stand-in for
// bsg_mem_1r1w_sync_mask_write_byte; contents are deliberately not reset.
module ethernet_tx_buffer #(
  parameter int width_p = 64,
  parameter int els_p = 256,
  localparam int addr_width_lp = $clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic [width_p/8-1:0]     w_mask_i,
  input  logic                     r_v_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  logic [width_p-1:0] mem_r [els_p];

  // Byte-masked write port.
  always_ff @(posedge clk_i) begin
    if (w_v_i) begin
      for (int i = 0; i < width_p/8; i++) begin
        if (w_mask_i[i]) mem_r[w_addr_i][8*i +: 8] <= w_data_i[8*i +: 8];
      end
    end
  end

  // Registered read; output holds its value until the next read enable.
  always_ff @(posedge clk_i) begin
    if (r_v_i) r_data_o <= mem_r[r_addr_i];
  end

endmodule

// File: rtl/ethernet_tx_ctrl.sv
// Register-mapped Ethernet transmit controller. Software fills the packet
// buffer, programs TX_LEN and writes TX_SEND; the frame is then streamed one
// byte per handshake on an AXI-Stream master port.
// Optional feature: define ETHERNET_TX_IRQ_EN to add the IRQ enable register
// at 0x818 and drive irq_o; otherwise irq_o is tied low.
module ethernet_tx_ctrl
  import bp_eth_pkg::*;
#(
  parameter int reg_width_p = 64,
  parameter int reg_addr_width_p = 40,
  parameter int buf_bytes_p = 2048,
  localparam int lg_reg_width_lp = 3
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        r_v_i,
  input  logic                        w_v_i,
  output logic                        w_yumi_o,
  input  logic [reg_addr_width_p-1:0] addr_i,
  input  logic [lg_reg_width_lp-1:0]  size_i,
  input  logic [reg_width_p-1:0]      data_i,
  output logic [reg_width_p-1:0]      data_o,
  output logic [7:0]                  tx_axis_tdata_o,
  output logic                        tx_axis_tvalid_o,
  input  logic                        tx_axis_tready_i,
  output logic                        tx_axis_tlast_o,
  output logic                        irq_o
);

  localparam int lg_buf_lp = $clog2(buf_bytes_p);
  localparam int word_addr_w_lp = lg_buf_lp - 3;
  localparam logic [12:0] buf_bytes_lp = 13'(buf_bytes_p);

  bp_eth_tx_state_e state_r;
  logic [11:0] byte_cnt_r;
  logic [11:0] tx_len_r;
  logic        err_r;
  logic        irq_pend_r;
  logic        irq_en_r;

  logic        busy;
  logic [11:0] off;
  logic [11:0] buf_off;
  logic        w_fire;
  logic        buf_hit;
  logic [7:0]  w_mask;
  logic        send_ok;
  logic        hs;
  logic        last;
  logic [11:0] byte_cnt_nxt;
  logic [reg_width_p-1:0] word_p1;
  logic        unused_addr;

  assign busy         = (state_r != e_idle);
  assign off          = addr_i[11:0];
  assign buf_off      = off - tx_buf_base;
  assign w_fire       = w_v_i & ~busy;
  assign w_yumi_o     = w_fire;
  assign buf_hit      = ({1'b0, buf_off} < buf_bytes_lp);
  assign w_mask       = bp_eth_byte_mask(size_i, addr_i[2:0]);
  assign send_ok      = (tx_len_r != 12'd0) && ({1'b0, tx_len_r} <= buf_bytes_lp);
  assign hs           = tx_axis_tvalid_o & tx_axis_tready_i;
  assign last         = (byte_cnt_r == (tx_len_r - 12'd1));
  assign byte_cnt_nxt = byte_cnt_r + 12'd1;
  assign unused_addr  = ^addr_i[reg_addr_width_p-1:12];

  ethernet_tx_buffer #(
    .width_p(reg_width_p),
    .els_p  (buf_bytes_p/8)
  ) buffer (
    .clk_i   (clk_i),
    .w_v_i   (w_fire & buf_hit),
    .w_addr_i(buf_off[lg_buf_lp-1:3]),
    .w_data_i(data_i),
    .w_mask_i(w_mask),
    .r_v_i   (state_r == e_fetch),
    .r_addr_i(byte_cnt_r[lg_buf_lp-1:3]),
    .r_data_o(word_p1)
  );

  // Stream outputs are decoded from state so reset removes tvalid at once;
  // byte_cnt and the fetched word stay put while the MAC back-pressures.
  assign tx_axis_tvalid_o = (state_r == e_send);
  assign tx_axis_tlast_o  = tx_axis_tvalid_o & last;
  assign tx_axis_tdata_o  = tx_axis_tvalid_o ? word_p1[{byte_cnt_r[2:0], 3'b000} +: 8] : 8'd0;

  // Transmit FSM: fetch one buffer word, then send its lanes, refetching at
  // each 8-byte boundary.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r    <= e_idle;
      byte_cnt_r <= 12'd0;
    end else begin
      case (state_r)
        e_idle: begin
          if (w_fire && (off == tx_send_offset) && send_ok) begin
            byte_cnt_r <= 12'd0;
            state_r    <= e_fetch;
          end
        end
        e_fetch: state_r <= e_send;
        e_send: begin
          if (hs) begin
            if (last) begin
              state_r <= e_idle;
            end else begin
              byte_cnt_r <= byte_cnt_nxt;
              if (byte_cnt_nxt[2:0] == 3'd0) state_r <= e_fetch;
            end
          end
        end
        default: state_r <= e_idle;
      endcase
    end
  end

  // Software-visible control registers; all writes land only while idle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tx_len_r   <= 12'd0;
      err_r      <= 1'b0;
      irq_pend_r <= 1'b0;
      irq_en_r   <= 1'b0;
    end else begin
      if (w_fire) begin
        case (off)
          tx_len_offset:  tx_len_r <= data_i[11:0];
          tx_send_offset: if (!send_ok) err_r <= 1'b1;
          tx_status_offset: begin
            err_r <= 1'b0;
            if (data_i[status_irq_pend_bit]) irq_pend_r <= 1'b0;
          end
`ifdef ETHERNET_TX_IRQ_EN
          tx_irq_en_offset: irq_en_r <= data_i[0];
`endif
          default: ;
        endcase
      end
      if (hs && last) irq_pend_r <= 1'b1;
    end
  end

`ifdef ETHERNET_TX_IRQ_EN
  assign irq_o = irq_pend_r & irq_en_r;
`else
  assign irq_o = 1'b0;
`endif

  // Combinational read mux; everything unmapped or write-only reads 0.
  always_comb begin
    data_o = '0;
    if (r_v_i) begin
      case (off)
        tx_len_offset: data_o[11:0] = tx_len_r;
        tx_status_offset: begin
          data_o[status_busy_bit]     = busy;
          data_o[status_err_bit]      = err_r;
          data_o[status_irq_pend_bit] = irq_pend_r;
        end
`ifdef ETHERNET_TX_IRQ_EN
        tx_irq_en_offset: data_o[0] = irq_en_r;
`endif
        default: ;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Read and write strobes in the same cycle indicate a broken decoder.
  always @(posedge clk_i) begin
    if (!reset_i) assert (!(r_v_i && w_v_i));
  end
`endif

endmodule

// File: tb/tb_ethernet_tx_ctrl.sv
// Self-checking bench for ethernet_tx_ctrl: randomized buffer contents and
// back-pressure, compared against a byte-array model of the packet buffer
// and the control registers.
module tb_ethernet_tx_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        r_v, w_v, w_yumi;
  logic [39:0] addr;
  logic [2:0]  size;
  logic [63:0] wdata, rdata;
  logic [7:0]  tdata;
  logic        tvalid, tready, tlast, irq;

  ethernet_tx_ctrl dut (
    .clk_i(clk), .reset_i(rst), .r_v_i(r_v), .w_v_i(w_v), .w_yumi_o(w_yumi),
    .addr_i(addr), .size_i(size), .data_i(wdata), .data_o(rdata),
    .tx_axis_tdata_o(tdata), .tx_axis_tvalid_o(tvalid),
    .tx_axis_tready_i(tready), .tx_axis_tlast_o(tlast), .irq_o(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model
  logic [7:0]  mem_model [2048];
  logic [11:0] m_len;
  logic        m_err, m_irq_pend, m_irq_en;
  logic [7:0]  exp_q[$];
  logic [7:0]  rxq[$];
  int          first_idx, bubbles, last_hs_cyc, yumi_cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_irq();
`ifdef ETHERNET_TX_IRQ_EN
    return m_irq_pend & m_irq_en;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [63:0] exp_status(input logic busy);
    return 64'({m_irq_pend, m_err, busy});
  endfunction

  task automatic model_reset();
    m_len = 12'd0; m_err = 1'b0; m_irq_pend = 1'b0; m_irq_en = 1'b0;
  endtask

  // Apply an accepted register write to the model.
  task automatic model_write(input logic [11:0] a, input logic [2:0] s, input logic [63:0] d);
    if (a < 12'd2048) begin
      for (int k = 0; k < (1 << s); k++) begin
        int lane;
        lane = int'(a[2:0]) + k;
        if (lane < 8) mem_model[int'(a & 12'hFF8) + lane] = d[8*lane +: 8];
      end
    end else if (a == 12'h800) begin
      m_len = d[11:0];
    end else if (a == 12'h808) begin
      if (m_len == 12'd0 || m_len > 12'd2048) m_err = 1'b1;
    end else if (a == 12'h810) begin
      m_err = 1'b0;
      if (d[2]) m_irq_pend = 1'b0;
    end else if (a == 12'h818) begin
`ifdef ETHERNET_TX_IRQ_EN
      m_irq_en = d[0];
`endif
    end
  endtask

  task automatic reg_write(input logic [11:0] a, input logic [2:0] s, input logic [63:0] d);
    int n;
    n = 0;
    @(negedge clk);
    w_v = 1'b1; addr = {28'd0, a}; size = s; wdata = d;
    #1;
    while (!w_yumi && n < 4000) begin
      @(negedge clk); #1; n++;
    end
    if (!w_yumi) begin
      check("write_timeout", 64'(n), 64'd0);
      w_v = 1'b0;
      return;
    end
    yumi_cyc = cyc;
    model_write(a, s, d);
    @(posedge clk); #1;
    w_v = 1'b0;
  endtask

  task automatic reg_read(input logic [11:0] a, output logic [63:0] v);
    @(negedge clk);
    r_v = 1'b1; addr = {28'd0, a};
    #1;
    v = rdata;
    r_v = 1'b0;
  endtask

  task automatic expect_frame(input int len);
    exp_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(mem_model[i]);
  endtask

  // Receive a frame; stop_at >= 0 returns once that many bytes are taken.
  task automatic collect(input int len, input bit rnd, input int stop_at);
    int n;
    bit stall;
    logic [7:0] pd;
    logic pl;
    n = 0; stall = 1'b0; pd = 8'd0; pl = 1'b0;
    rxq.delete(); first_idx = -1; bubbles = 0;
    forever begin
      @(negedge clk);
      if (stop_at >= 0 && rxq.size() == stop_at) begin
        tready = 1'b0; #1;
        return;
      end
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (stall) begin
        check("hold_tvalid", 64'(tvalid), 64'd1);
        check("hold_tdata", 64'(tdata), 64'(pd));
        check("hold_tlast", 64'(tlast), 64'(pl));
      end
      if (tvalid && first_idx < 0) first_idx = n;
      if (!tvalid && first_idx >= 0) bubbles++;
      stall = tvalid && !tready; pd = tdata; pl = tlast;
      if (tvalid && tready) begin
        check("tlast", 64'(tlast), 64'(rxq.size() == len - 1));
        rxq.push_back(tdata);
        if (tlast || rxq.size() > len) begin
          last_hs_cyc = cyc;
          @(posedge clk); #1;
          return;
        end
      end
      n++;
      if (n > 3000) begin
        check("rx_timeout", 64'(n), 64'd0);
        return;
      end
    end
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_len"}, 64'(rxq.size()), 64'(exp_q.size()));
    for (int i = 0; i < rxq.size() && i < exp_q.size(); i++)
      check(tag, 64'(rxq[i]), 64'(exp_q[i]));
  endtask

  task automatic send_frame(input int len);
    reg_write(12'h800, 3'd3, 64'(len));
    expect_frame(len);
    reg_write(12'h808, 3'd3, 64'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] v;
    int cnt;
    rst = 1'b1; r_v = 1'b0; w_v = 1'b0; addr = '0; size = '0; wdata = '0; tready = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_tlast", 64'(tlast), 64'd0);
    check("rst_tdata", 64'(tdata), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    reg_read(12'h800, v); check("rst_len", v, 64'd0);
    reg_read(12'h810, v); check("rst_status", v, 64'd0);
    @(negedge clk); rst = 1'b0;

    // Counting pattern, 60-byte frame, free-running MAC
    for (int k = 0; k < 8; k++)
      reg_write(12'(8*k), 3'd3, 64'h0706050403020100 + 64'(k) * 64'h0808080808080808);
    send_frame(60);
    reg_read(12'h810, v); check("busy_during", v, exp_status(1'b1));
    collect(60, 1'b0, -1);
    m_irq_pend = 1'b1;
    check_frame("f60");
    if (rxq.size() == 60) check("f60_last_byte", 64'(rxq[59]), 64'h3B);
    check("f60_bubbles", 64'(bubbles), 64'd7);
    reg_read(12'h810, v); check("busy_after", v, exp_status(1'b0));
    check("irq_f60", 64'(irq), 64'(exp_irq()));
    reg_read(12'h000, v); check("buf_read_zero", v, 64'd0);

    // Single-byte frame and SEND latency
    send_frame(1);
    collect(1, 1'b0, -1);
    check_frame("f1");
    check("latency", 64'(first_idx), 64'd1);

    // Illegal lengths raise err and transmit nothing
    reg_write(12'h800, 3'd3, 64'd0);
    reg_write(12'h808, 3'd3, 64'd1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (tvalid) cnt++;
    end
    check("len0_no_tvalid", 64'(cnt), 64'd0);
    reg_read(12'h810, v); check("len0_err", v, exp_status(1'b0));
    reg_write(12'h810, 3'd3, 64'd0);
    reg_read(12'h810, v); check("err_clear", v, exp_status(1'b0));
    reg_write(12'h800, 3'd3, 64'd2049);
    reg_write(12'h808, 3'd3, 64'd1);
    reg_read(12'h810, v); check("len2049_err", v, exp_status(1'b0));
    reg_write(12'h810, 3'd3, 64'd4);
    reg_read(12'h810, v); check("status_clear_all", v, exp_status(1'b0));

    // Narrow writes touch only the addressed lanes
    reg_write(12'h003, 3'd0, 64'hAAAAAAAAAAAAAAAA);
    reg_write(12'h006, 3'd1, 64'hBEEFBEEFBEEFBEEF);
    send_frame(8);
    collect(8, 1'b0, -1);
    check_frame("narrow");
    if (rxq.size() == 8) begin
      check("narrow_b3", 64'(rxq[3]), 64'hAA);
      check("narrow_b6", 64'(rxq[6]), 64'hEF);
      check("narrow_b7", 64'(rxq[7]), 64'hBE);
      check("narrow_b2", 64'(rxq[2]), 64'h02);
    end
    reg_read(12'h800, v); check("len_readback", v, 64'd8);

    // Random contents, random narrow overwrites, random back-pressure
    for (int k = 0; k < 13; k++)
      reg_write(12'(8*k), 3'd3, {$urandom, $urandom});
    for (int k = 0; k < 8; k++)
      reg_write(12'($urandom_range(0, 103)), 3'($urandom_range(0, 3)), {$urandom, $urandom});
    send_frame(100);
    collect(100, 1'b1, -1);
    check_frame("rand100");

    // Write stalls while busy and lands the cycle after tlast
    send_frame(24);
    fork
      collect(24, 1'b0, -1);
      reg_write(12'h010, 3'd3, {$urandom, $urandom});
    join
    check_frame("stall24");
    check("yumi_after_tlast", 64'(yumi_cyc), 64'(last_hs_cyc + 1));

    // Interrupt path
    reg_write(12'h810, 3'd3, 64'd4);
    reg_write(12'h818, 3'd3, 64'd1);
    reg_read(12'h818, v);
`ifdef ETHERNET_TX_IRQ_EN
    check("irq_en_read", v, 64'd1);
`else
    check("irq_en_read", v, 64'd0);
`endif
    @(negedge clk); #1; check("irq_idle", 64'(irq), 64'(exp_irq()));
    send_frame(4);
    collect(4, 1'b0, -1);
    m_irq_pend = 1'b1;
    check_frame("irq4");
    @(negedge clk); #1; check("irq_done", 64'(irq), 64'(exp_irq()));
    reg_write(12'h810, 3'd3, 64'd0);
    @(negedge clk); #1; check("irq_kept", 64'(irq), 64'(exp_irq()));
    reg_read(12'h810, v); check("irq_pend_vis", v, exp_status(1'b0));
    reg_write(12'h810, 3'd3, 64'd4);
    @(negedge clk); #1; check("irq_cleared", 64'(irq), 64'(exp_irq()));

    // Reset in the middle of a frame
    send_frame(40);
    collect(40, 1'b0, 20);
    check("midrst_tvalid_before", 64'(tvalid), 64'd1);
    check("midrst_byte20", 64'(tdata), 64'(exp_q[20]));
    rst = 1'b1;
    #1;
    model_reset();
    check("midrst_tvalid", 64'(tvalid), 64'd0);
    reg_read(12'h810, v); check("midrst_status", v, 64'd0);
    reg_read(12'h800, v); check("midrst_len", v, 64'd0);
    @(negedge clk); rst = 1'b0;
    send_frame(8);
    collect(8, 1'b0, -1);
    check_frame("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ethernet_tx_ctrl.md
Name: ethernet_tx_ctrl

Overview:
- Register-mapped Ethernet transmit controller, one element of the BedRock register decoder.
- Consumes the decoder's per-element r_v/w_v/w_yumi/addr/size/data register port.
- Software writes a frame into an internal packet buffer, programs its length, then writes SEND.
- The block streams the frame bytewise on an AXI-Stream master port toward the Ethernet MAC TX FIFO.

Parameters:
- reg_width_p, 64, register data width in bits; fixed at 64.
- reg_addr_width_p, 40, width of addr_i; only addr_i[11:0] is decoded.
- buf_bytes_p, 2048, packet buffer capacity in bytes; power of two, ≥ 64.
- lg_reg_width_lp, 3 (local), width of size_i = clog2 of log2(reg_width_p/8) range.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- r_v_i  in  1  read strobe; read data must be valid on data_o in the same cycle.
- w_v_i  in  1  write request, held until w_yumi_o.
- w_yumi_o  out  1  write accepted this cycle.
- addr_i  in  reg_addr_width_p  byte address.
- size_i  in  lg_reg_width_lp  log2 of access bytes (0..3).
- data_i  in  reg_width_p  write data, already replicated across byte lanes.
- data_o  out  reg_width_p  read data.
- tx_axis_tdata_o  out  8  frame byte.
- tx_axis_tvalid_o  out  1  byte valid.
- tx_axis_tready_i  in  1  MAC ready.
- tx_axis_tlast_o  out  1  last byte of frame.
- irq_o  out  1  completion interrupt (see Optional Feature).

Behaviour:
- Register map, offsets from addr_i[11:0]:
  - 0x000..buf_bytes_p-1: TX buffer, write-only; reads return 0.
  - 0x800: TX_LEN, R/W, bits[11:0].
  - 0x808: TX_SEND, write-only; any write requests transmit.
  - 0x810: TX_STATUS, read-only bits {2:irq_pend, 1:err, 0:busy}; a write clears err, and clears irq_pend where data bit 2 = 1.
  - Other offsets: writes accepted and dropped; reads return 0.
- Byte-lane write mask:
  - mask = ((1<<(1<<size_i))-1) << addr_i[2:0], truncated to 8 bits.
  - Buffer words are 64-bit; word index = addr_i[10:3].
- Write handshake:
  - w_yumi_o = w_v_i & ~busy (combinational). Every write stalls while busy, including writes to TX_STATUS.
  - Writes never stall while idle.
- Reads:
  - data_o is combinational, 0 when r_v_i = 0.
  - Reads never stall and are legal while busy.
  - r_v_i & w_v_i together is illegal and asserted against in simulation.
- SEND write:
  - Sets err and stays idle when TX_LEN == 0 or TX_LEN > buf_bytes_p.
  - Otherwise sets busy and starts the FSM.
- FSM states:
  - e_idle: on valid SEND, clear byte_cnt and go to e_fetch.
  - e_fetch: issue synchronous buffer read of word byte_cnt[10:3]; data registered next cycle; go to e_send. One bubble cycle per 8 bytes.
  - e_send:
    - tvalid = 1; tdata = word byte lane byte_cnt[2:0]; tlast = (byte_cnt == TX_LEN-1).
    - On tvalid & tready: byte_cnt++.
    - If tlast: go to e_idle, busy = 0, set irq_pend.
    - Else if the new byte_cnt[2:0] == 0: go to e_fetch.
    - While tready = 0: tdata and tlast held stable; tvalid never drops before the handshake.
- TX_LEN: sampled at the SEND write and held internally while busy; TX_LEN writes stall while busy.
- Reset values:
  - tvalid, tlast, tdata, busy, err, irq_pend, irq_o, TX_LEN, byte_cnt = 0; FSM = e_idle.
  - Buffer contents are not reset.
  - Reset asserted mid-frame drops the frame immediately; tvalid goes 0 asynchronously.
- Latency: SEND accepted in cycle N gives the first tvalid in cycle N+2 (idle→fetch→send).
- Widths: byte_cnt is 12 bits; comparisons use TX_LEN zero-extended.

Optional Feature:
- Macro: ETHERNET_TX_IRQ_EN.
- When defined:
  - irq_o = irq_pend & irq_en.
  - irq_en is bit 0 of a new R/W register at 0x818, reset 0.
- When undefined:
  - irq_o is tied 0.
  - 0x818 reads 0, and writes to it are dropped.
  - irq_pend is still visible in TX_STATUS for polling.

Decomposition:
- Shared package bp_eth_pkg holds:
  - Register offset constants: tx_buf_base, tx_len_offset, tx_send_offset, tx_status_offset, tx_irq_en_offset.
  - Status bit positions.
  - FSM enum bp_eth_tx_state_e.
- Sub-module ethernet_tx_buffer: 64-bit × (buf_bytes_p/8) 1r1w memory with byte-mask write and one-cycle synchronous read, wrapping bsg_mem_1r1w_sync_mask_write_byte.

Test Plan:
- Write 8 dwords 0x0706050403020100+k·0x0808080808080808; TX_LEN = 60; SEND; tready = 1 → bytes 0x00..0x3B in order, tlast on byte 59, exactly 7 fetch bubbles, busy reads 1 then 0, irq_pend = 1.
- TX_LEN = 1, SEND → a single byte with tlast = 1; TX_LEN = 0, SEND → no tvalid, err = 1; a write to TX_STATUS clears err.
- Narrow writes: size 0 to offset 0x003 with data 0xAA replicated, then size 1 to offset 0x006 = 0xBEEF → only lanes 3, 6 and 7 change, verified via frame bytes 3 (0xAA), 6 (0xEF), 7 (0xBE).
- Random tready toggling during a 100-byte frame → tdata/tlast stable while tvalid & ~tready; no bytes lost or duplicated.
- Buffer write issued while busy → w_yumi_o stays 0 until the tlast handshake, then 1 in the next cycle; a TX_STATUS read while busy returns busy = 1 with no stall.
- Reset asserted mid-frame at byte 20 → tvalid drops, busy = 0; with ETHERNET_TX_IRQ_EN and irq_en = 1, a completed frame drives irq_o = 1 until TX_STATUS is written with bit 2 = 1.
